// File: rtl/pmux_rr_arbiter_pkg.sv
// Shared types and sizing for the pmux round-robin arbiter.
package pmux_rr_arbiter_pkg;

   localparam int DEFAULT_N = 3;
   localparam int DEFAULT_W = 2;
   localparam int STALL_W   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Pointer width that still works for a single requester.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pmux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo N, returned as a one-hot winner.
module rr_pick
   import pmux_rr_arbiter_pkg::*;
#(
   parameter int N = DEFAULT_N,
   localparam int PTR_W = ptr_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     winner
);

   logic [N-1:0] req_rot;
   logic [N-1:0] win_rot;
   logic         found;

   // Rotate requests so ptr sits at bit 0, take the lowest set bit,
   // then rotate the one-hot result back into requester order.
   always_comb begin
      req_rot = N'({req, req} >> ptr);
      win_rot = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_rot[i] && !found) begin
            win_rot[i] = 1'b1;
            found      = 1'b1;
         end
      end
      winner = N'(({win_rot, win_rot} << ptr) >> N);
   end

endmodule

// File: rtl/pmux_rr_arbiter.sv
// Round-robin arbiter that drives the A/B/S ports of a pmux cell and
// presents one grant at a time with a valid/ready handshake.
module pmux_rr_arbiter
   import pmux_rr_arbiter_pkg::*;
#(
   parameter int N = DEFAULT_N,
   parameter int W = DEFAULT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*W-1:0]     din,
   input  logic [W-1:0]       dflt,
   input  logic               out_ready,
   output logic [N-1:0]       sel,
   output logic [W-1:0]       a_out,
   output logic [N*W-1:0]     b_out,
   output logic               out_valid,
   output logic [N-1:0]       ack,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam int PTR_W = ptr_width(N);

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [N-1:0]     winner;
   logic             xfer;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (winner)
   );

   assign xfer = out_valid & out_ready;
   assign ack  = sel & {N{xfer}};

   // State register; reset always returns to IDLE, dropping any grant.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: leave IDLE on any request, leave GRANT on a transfer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = GRANT;
         GRANT:   if (xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pointer advances to the slot just after the granted requester.
   always_comb begin
      ptr_nxt = ptr;
      for (int i = 0; i < N; i++) begin
         if (sel[i]) ptr_nxt = (i == N - 1) ? '0 : PTR_W'(i + 1);
      end
   end

   // Grant registers: load winner and data on entry to GRANT, hold them
   // until the transfer, then clear the grant and move the pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel       <= '0;
         b_out     <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  sel       <= winner;
                  b_out     <= din;
                  out_valid <= 1'b1;
               end
            end
            GRANT: begin
               if (xfer) begin
                  sel       <= '0;
                  out_valid <= 1'b0;
                  ptr       <= ptr_nxt;
               end
            end
            default: begin
               sel       <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Default value is simply retimed every cycle regardless of state.
   always_ff @(posedge clk) begin
      if (rst) a_out <= '0;
      else     a_out <= dflt;
   end

   // Count stalled cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pmux_rr_arbiter.sv
// Self-checking bench for pmux_rr_arbiter with a grant scoreboard.
module tb_pmux_rr_arbiter;

   localparam int N = 3;
   localparam int W = 2;

   typedef struct packed {
      logic [N-1:0]   sel;
      logic [N*W-1:0] data;
   } exp_t;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] din;
   logic [W-1:0]   dflt;
   logic           out_ready;
   logic [N-1:0]   sel;
   logic [W-1:0]   a_out;
   logic [N*W-1:0] b_out;
   logic           out_valid;
   logic [N-1:0]   ack;
   logic [7:0]     stall_cnt;

   exp_t sb[$];
   exp_t mon_e;
   logic mon_en;
   int   tests_run;
   int   tests_failed;

   logic [N-1:0]   rr_exp [4];
   logic [N*W-1:0] rr_din [4];

   pmux_rr_arbiter #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din       (din),
      .dflt      (dflt),
      .out_ready (out_ready),
      .sel       (sel),
      .a_out     (a_out),
      .b_out     (b_out),
      .out_valid (out_valid),
      .ack       (ack),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
      req       = r;
      din       = d;
      out_ready = rdy;
   endtask

   task automatic pulseReset(input int cycles);
      rst = 1'b1;
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   // Every acknowledged grant must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("sel_onehot", 32'($countones(sel) <= 1), 32'd1);
         if (ack != '0) begin
            if (sb.size() == 0) begin
               checkOutput("ack_unexpected", 32'(ack), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               checkOutput("sb_ack", 32'(ack), 32'(mon_e.sel));
               checkOutput("sb_b_out", 32'(b_out), 32'(mon_e.data));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      mon_en       = 1'b0;
      rst          = 1'b1;
      dflt         = '0;
      applyStimulus(3'b000, '0, 1'b0);

      // Reset state
      pulseReset(2);
      checkOutput("rst_sel", 32'(sel), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_ack", 32'(ack), 32'd0);
      checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
      checkOutput("rst_b_out", 32'(b_out), 32'd0);
      checkOutput("rst_a_out", 32'(a_out), 32'd0);
      mon_en = 1'b1;

      // Single request with immediate acceptance
      dflt = 2'd2;
      applyStimulus(3'b001, 6'd57, 1'b1);
      sb.push_back('{sel: 3'b001, data: 6'd57});
      step();
      checkOutput("single_sel", 32'(sel), 32'b001);
      checkOutput("single_valid", 32'(out_valid), 32'd1);
      checkOutput("single_b_out", 32'(b_out), 32'd57);
      checkOutput("single_ack", 32'(ack), 32'b001);
      checkOutput("a_out_dflt", 32'(a_out), 32'd2);
      req = 3'b000;
      step();
      checkOutput("single_release", 32'(sel), 32'd0);
      checkOutput("single_valid_low", 32'(out_valid), 32'd0);

      // Round-robin with all requesters active from ptr=0
      pulseReset(1);
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      rr_din[0] = 6'h2D;  rr_din[1] = 6'h12;  rr_din[2] = 6'h3F;  rr_din[3] = 6'h05;
      dflt = 2'd1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b111, rr_din[k], 1'b1);
         sb.push_back('{sel: rr_exp[k], data: rr_din[k]});
         step();
         checkOutput("rr_grant", 32'(sel), 32'(rr_exp[k]));
         din = ~rr_din[k];
         step();
         checkOutput("rr_bubble", 32'(sel), 32'd0);
      end
      checkOutput("a_out_dflt2", 32'(a_out), 32'd1);
      req = 3'b000;

      // Backpressure holds the grant and counts stalls
      pulseReset(1);
      applyStimulus(3'b110, 6'h1B, 1'b0);
      sb.push_back('{sel: 3'b010, data: 6'h1B});
      step();
      din = 6'h00;
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_sel_stable", 32'(sel), 32'b010);
         step();
      end
      checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd5);
      checkOutput("bp_b_out_held", 32'(b_out), 32'h1B);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_ack", 32'(ack), 32'b010);
      din = 6'h36;
      sb.push_back('{sel: 3'b100, data: 6'h36});
      step();
      checkOutput("bp_bubble", 32'(sel), 32'd0);
      step();
      checkOutput("bp_ptr2_grant", 32'(sel), 32'b100);
      req = 3'b000;
      step();

      // Stall counter saturates
      pulseReset(1);
      applyStimulus(3'b001, 6'h2A, 1'b0);
      sb.push_back('{sel: 3'b001, data: 6'h2A});
      step();
      repeat (100) step();
      checkOutput("sat_mid", 32'(stall_cnt), 32'd100);
      repeat (200) step();
      checkOutput("sat_cap", 32'(stall_cnt), 32'd255);
      checkOutput("sat_sel_held", 32'(sel), 32'b001);
      applyStimulus(3'b000, 6'h2A, 1'b1);
      step();
      checkOutput("sat_after_xfer", 32'(stall_cnt), 32'd255);

      // Reset in the middle of a grant (ptr=1 here, so 101 picks 100)
      applyStimulus(3'b101, 6'h11, 1'b0);
      step();
      checkOutput("midrst_pre_sel", 32'(sel), 32'b100);
      rst = 1'b1;
      step();
      checkOutput("midrst_sel", 32'(sel), 32'd0);
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_ack", 32'(ack), 32'd0);
      checkOutput("midrst_stall", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      applyStimulus(3'b101, 6'h22, 1'b1);
      sb.push_back('{sel: 3'b001, data: 6'h22});
      step();
      checkOutput("midrst_regrant", 32'(sel), 32'b001);
      req = 3'b000;
      step();
      step();
      checkOutput("final_idle", 32'(out_valid), 32'd0);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pmux_rr_arbiter.md
PMUX_RR_ARBITER -- requirements
Module: pmux_rr_arbiter

Interface
REQ-001 Parameter N, default 3, number of requesters; it equals the width of the pmux select.
REQ-002 Parameter W, default 2, width of each data slice and of the default value.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N  per-requester request level.
REQ-006 din  input  N*W  flattened request data; slice i is din[i*W+W-1 : i*W].
REQ-007 dflt  input  W  default value, passed to the pmux A port.
REQ-008 out_ready  input  1  downstream accepts the current selection.
REQ-009 sel  output  N  registered one-hot grant, driving pmux S; all zero when nothing is granted.
REQ-010 a_out  output  W  registered copy of dflt, driving pmux A.
REQ-011 b_out  output  N*W  registered copy of din captured at grant, driving pmux B.
REQ-012 out_valid  output  1  registered; high while a grant is presented.
REQ-013 ack  output  N  combinational; ack = sel AND (out_valid AND out_ready), replicated across N.
REQ-014 stall_cnt  output  8  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 The FSM shall have two states, IDLE and GRANT; it enters IDLE on reset.
REQ-016 In IDLE with req≠0, the block shall search for the first set req bit starting at index ptr and wrapping modulo N, then enter GRANT on the next edge.
REQ-017 On entry to GRANT, the block shall load sel with the winner's one-hot code, capture din into b_out, and set out_valid=1.
REQ-018 In GRANT, sel, b_out and out_valid shall stay stable until a transfer occurs (out_valid AND out_ready), even if req of the winner drops.
REQ-019 On a transfer edge, the block shall set ptr to (winner+1) mod N, clear sel and out_valid, and return to IDLE.
REQ-020 Throughput shall be at most one transfer every 2 cycles; IDLE is always a one-cycle bubble.
REQ-021 Grant latency shall be one cycle: a req sampled in IDLE yields sel valid on the following cycle.
REQ-022 In IDLE with req=0, sel=0 and out_valid=0, so the pmux outputs a_out.
REQ-023 a_out shall register dflt every cycle, independent of state.
REQ-024 stall_cnt shall increment on every stall cycle, saturate at 255, and never wrap.
REQ-025 sel shall never have more than one bit set.
REQ-026 If req changes in the same cycle the FSM leaves IDLE, the value sampled at that edge decides the grant.

Reset
REQ-027 While rst=1 at a rising edge, the block shall set state=IDLE, ptr=0, sel=0, out_valid=0, b_out=0, a_out=0 and stall_cnt=0.
REQ-028 Reset asserted mid-GRANT shall drop the grant at that edge with no ack; the pending request is re-arbitrated afterwards from ptr=0.
REQ-029 ack shall be 0 during reset, as a consequence of out_valid=0.

Structure
REQ-030 A shared package shall hold the state enum (IDLE, GRANT), the stall counter width (8) and the default N and W.
REQ-031 A sub-module rr_pick shall hold the combinational priority search: inputs req and ptr, output a one-hot winner.
REQ-032 The top level shall contain the FSM, ptr, the output registers and the stall counter.

Verification (N=3, W=2)
REQ-033 Reset: rst=1 for 2 cycles -> sel=000, out_valid=0, ack=000, stall_cnt=0, b_out=0.
REQ-034 Single request: req=001, din=57, out_ready=1 -> next cycle sel=001, out_valid=1, b_out=57, ack=001 in that cycle; the following cycle sel=000.
REQ-035 Round-robin: req=111 held, out_ready=1 -> grants 001, 010, 100, 001 on every second cycle.
REQ-036 Backpressure: ptr=0, req=110, out_ready=0 for 5 cycles -> sel=010 stable, stall_cnt=5; raising out_ready -> ack=010, then ptr=2.
REQ-037 Saturation: out_ready=0 for 300 cycles with a grant held -> stall_cnt=255.
REQ-038 Reset mid-GRANT: sel=100 and rst pulsed -> sel=000 and out_valid=0 at the next edge; with req=101 still held, the next grant is 001.
